// File: rtl/fir_pkg.sv
// Shared defaults for the FIR output sink: widths, rounding shift,
// FIFO depth and the round-half-up constant.
package fir_pkg;

  localparam int FIR_IN_W  = 38;
  localparam int FIR_OUT_W = 16;
  localparam int FIR_SHIFT = 15;
  localparam int FIR_DEPTH = 8;

  // Half an output LSB, i.e. 2^(sh-1).
  function automatic longint unsigned fir_rnd(input int sh);
    return 64'd1 << (sh - 1);
  endfunction

  localparam longint unsigned FIR_RND = fir_rnd(FIR_SHIFT);

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up then saturate a wide FIR result to the output width.
// Purely combinational; sat flags a clipped sample.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int InputWidth  = FIR_IN_W,
  parameter int OutputWidth = FIR_OUT_W,
  parameter int Shift       = FIR_SHIFT
) (
  input  logic [InputWidth-1:0]  din,
  output logic [OutputWidth-1:0] dout,
  output logic                   sat
);

  localparam int SW = InputWidth + 1;
  localparam logic [SW-1:0] RND = SW'(fir_rnd(Shift));

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] rounded;
  logic                 fits;
  logic                 neg;

  // Extra headroom bit keeps the rounding add from wrapping.
  always_comb begin
    sum     = $signed({din[InputWidth-1], din}) + $signed(RND);
    rounded = sum >>> Shift;
    neg     = rounded[SW-1];
    fits    = (rounded[SW-1:OutputWidth-1] == '0) ||
              (rounded[SW-1:OutputWidth-1] == '1);
    sat     = !fits;
    if (fits)
      dout = rounded[OutputWidth-1:0];
    else if (neg)
      dout = {1'b1, {(OutputWidth-1){1'b0}}};
    else
      dout = {1'b0, {(OutputWidth-1){1'b1}}};
  end

endmodule

// File: rtl/fir_output_sink.sv
// Rounds FIR results into a small FIFO feeding a valid/ready sink,
// with sticky overflow/saturation flags and a saturating drop counter.
module fir_output_sink
  import fir_pkg::*;
#(
  parameter int InputWidth  = FIR_IN_W,
  parameter int OutputWidth = FIR_OUT_W,
  parameter int Shift       = FIR_SHIFT,
  parameter int Depth       = FIR_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     firValid,
  input  logic [InputWidth-1:0]    firData,
  input  logic                     outReady,
  input  logic                     clrOverflow,
  output logic                     outValid,
  output logic [OutputWidth-1:0]   dout,
  output logic [$clog2(Depth):0]   level,
  output logic                     overflow,
  output logic [7:0]               dropCount,
  output logic                     satFlag
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;

  logic [OutputWidth-1:0] mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic          sat_q, sat_d;

  logic [OutputWidth-1:0] sample;
  logic                   sample_sat;
  logic empty, full, push, pop, drop;

  fir_round_sat #(
    .InputWidth (InputWidth),
    .OutputWidth(OutputWidth),
    .Shift      (Shift)
  ) u_round_sat (
    .din (firData),
    .dout(sample),
    .sat (sample_sat)
  );

  // Handshake decode, pointer/level update and flag next-state.
  always_comb begin
    empty      = (level_q == '0);
    full       = (level_q == LW'(Depth));
    pop        = !empty && outReady;
    push       = firValid && (!full || pop);
    drop       = firValid && full && !pop;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);
    overflow_d = drop || (overflow_q && !clrOverflow);
    drop_d     = drop_q;
    if (drop) begin
      if (clrOverflow)
        drop_d = 8'd1;
      else if (drop_q != 8'hff)
        drop_d = drop_q + 8'd1;
    end else if (clrOverflow) begin
      drop_d = 8'd0;
    end
    sat_d      = (push && sample_sat) || (sat_q && !clrOverflow);
  end

  // Control state; contents discarded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
      sat_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      sat_q      <= sat_d;
    end
  end

  // Sample storage, left unreset.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= sample;
  end

  // Outputs come from registered state only.
  always_comb begin
    outValid  = !empty;
    dout      = empty ? '0 : mem_q[rd_ptr_q];
    level     = level_q;
    overflow  = overflow_q;
    dropCount = drop_q;
    satFlag   = sat_q;
  end

endmodule

// File: tb/tb_fir_output_sink.sv
// Directed bench for fir_output_sink: rounding/saturation table plus
// FIFO fill, drain, overflow, clear and reset sequences.
module tb_fir_output_sink;

  logic               clk = 1'b0;
  logic               rst;
  logic               firValid;
  logic signed [37:0] firData;
  logic               outReady;
  logic               clrOverflow;
  logic               outValid;
  logic [15:0]        dout;
  logic [3:0]         level;
  logic               overflow;
  logic [7:0]         dropCount;
  logic               satFlag;

  int checks = 0;
  int errors = 0;

  fir_output_sink dut (
    .clk        (clk),
    .rst        (rst),
    .firValid   (firValid),
    .firData    (firData),
    .outReady   (outReady),
    .clrOverflow(clrOverflow),
    .outValid   (outValid),
    .dout       (dout),
    .level      (level),
    .overflow   (overflow),
    .dropCount  (dropCount),
    .satFlag    (satFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [37:0] d;
    longint             q;
    bit                 s;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sd(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  task automatic clr_flags();
    firValid    = 1'b0;
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int i = 0; i < 20 && outValid; i++) tick();
    outReady = 1'b0;
    chk("drain_empty", longint'(outValid), 0);
  endtask

  initial begin
    tv[0] = '{38'sd16384,        1,      0};
    tv[1] = '{38'sd16383,        0,      0};
    tv[2] = '{-38'sd16385,      -1,      0};
    tv[3] = '{-38'sd16384,       0,      0};
    tv[4] = '{38'sd1073741824,   32767,  1};
    tv[5] = '{-38'sd2147483648, -32768,  1};
    tv[6] = '{38'sd1073709056,   32767,  0};
    tv[7] = '{38'sd1073725440,   32767,  1};
    tv[8] = '{-38'sd1073741824, -32768,  0};
    tv[9] = '{-38'sd1073758209, -32768,  1};

    rst = 1'b0;
    firValid = 1'b0;
    firData = '0;
    outReady = 1'b0;
    clrOverflow = 1'b0;
    #12;
    chk("rst_valid", longint'(outValid), 0);
    chk("rst_dout", sd(dout), 0);
    chk("rst_level", longint'(level), 0);
    chk("rst_ovf", longint'(overflow), 0);
    chk("rst_drop", longint'(dropCount), 0);
    chk("rst_sat", longint'(satFlag), 0);
    tick();
    rst = 1'b1;
    tick();

    // Rounding and saturation table, one sample at a time.
    for (int i = 0; i < 10; i++) begin
      clr_flags();
      firValid = 1'b1;
      firData  = tv[i].d;
      tick();
      firValid = 1'b0;
      chk($sformatf("tv%0d_valid", i), longint'(outValid), 1);
      chk($sformatf("tv%0d_dout", i), sd(dout), tv[i].q);
      chk($sformatf("tv%0d_sat", i), longint'(satFlag), longint'(tv[i].s));
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      chk($sformatf("tv%0d_level", i), longint'(level), 0);
    end

    // Overfill with 1..10, then drain in order.
    clr_flags();
    for (int k = 1; k <= 10; k++) begin
      firValid = 1'b1;
      firData  = 38'(k) <<< 15;
      tick();
    end
    firValid = 1'b0;
    chk("fill_level", longint'(level), 8);
    chk("fill_ovf", longint'(overflow), 1);
    chk("fill_drop", longint'(dropCount), 2);
    outReady = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_valid", k), longint'(outValid), 1);
      chk($sformatf("drain%0d_dout", k), sd(dout), k);
      tick();
    end
    outReady = 1'b0;
    chk("drain_done", longint'(outValid), 0);
    chk("drain_level", longint'(level), 0);

    // Full FIFO with simultaneous push and pop.
    clr_flags();
    for (int k = 1; k <= 8; k++) begin
      firValid = 1'b1;
      firData  = 38'(k) <<< 15;
      tick();
    end
    for (int k = 9; k <= 28; k++) begin
      firValid = 1'b1;
      outReady = 1'b1;
      firData  = 38'(k) <<< 15;
      chk($sformatf("thru%0d_head", k), sd(dout), k - 8);
      tick();
      chk($sformatf("thru%0d_level", k), longint'(level), 8);
    end
    firValid = 1'b0;
    chk("thru_drop", longint'(dropCount), 0);
    chk("thru_ovf", longint'(overflow), 0);
    for (int k = 21; k <= 28; k++) begin
      chk($sformatf("thru_tail%0d", k), sd(dout), k);
      tick();
    end
    outReady = 1'b0;
    chk("thru_empty", longint'(outValid), 0);

    // Drop counter saturation and clear.
    for (int k = 0; k < 300; k++) begin
      firValid = 1'b1;
      firData  = 38'(k) <<< 15;
      tick();
    end
    firValid = 1'b0;
    chk("sat255_drop", longint'(dropCount), 255);
    chk("sat255_ovf", longint'(overflow), 1);
    clr_flags();
    chk("clr_drop", longint'(dropCount), 0);
    chk("clr_ovf", longint'(overflow), 0);
    firValid    = 1'b1;
    clrOverflow = 1'b1;
    tick();
    firValid    = 1'b0;
    clrOverflow = 1'b0;
    chk("clrdrop_ovf", longint'(overflow), 1);
    chk("clrdrop_cnt", longint'(dropCount), 1);
    chk("clrdrop_level", longint'(level), 8);
    drain();

    // Asynchronous reset mid-stream.
    for (int k = 1; k <= 5; k++) begin
      firValid = 1'b1;
      firData  = 38'(k) <<< 15;
      tick();
    end
    firValid = 1'b0;
    chk("pre_rst_level", longint'(level), 5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", longint'(outValid), 0);
    chk("arst_level", longint'(level), 0);
    chk("arst_dout", sd(dout), 0);
    chk("arst_drop", longint'(dropCount), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_level", longint'(level), 0);
    firValid = 1'b1;
    firData  = 38'sd7 <<< 15;
    tick();
    firValid = 1'b0;
    chk("post_rst_valid", longint'(outValid), 1);
    chk("post_rst_dout", sd(dout), 7);
    chk("post_rst_lvl1", longint'(level), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
